// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle RV32I subset core.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // funct3 selects the operation; sub only matters for funct3=000
    function automatic alu_op_t funct3_op(input logic [2:0] f3,
                                          input logic       sub);
        alu_op_t op;
        op = ALU_ADD;
        unique case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Purely combinational 8-operation integer ALU.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_t     op_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = 32'd0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << b_i[4:0];
            ALU_SRL: result_o = a_i >> b_i[4:0];
            ALU_SLT: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I subset core: PC, ROM, regfile, decode, imm, ALU.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out_check,
    output logic [31:0] instruction_check,
    output logic [2:0]  alu_op_check,
    output logic [31:0] register_data_out1_check,
    output logic [31:0] register_data_out2_check,
    output logic [31:0] register_data_in_check,
    output logic [31:0] alu_result_check,
    output logic        reg_write_check,
    output logic [31:0] imm_ext_check,
    output logic        use_imm_check
);

    localparam int IDX_W = $clog2(IMEM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [1:31];
    logic [31:0] instr;
    logic [IDX_W-1:0] rom_idx;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm_ext, op_b, result;
    alu_op_t     alu_op;
    logic        use_imm, reg_write;

    assign pc_d    = pc_q + 32'd4;
    assign rom_idx = pc_q[IDX_W+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= 32'd0;
        else       pc_q <= pc_d;
    end

    always_comb begin
        instr = INSTR_NOP;
        case (rom_idx)
            IDX_W'(0): instr = 32'h0053_03b3;
            IDX_W'(1): instr = 32'h4084_8533;
            IDX_W'(2): instr = 32'h0016_0693;
            default:   instr = INSTR_NOP;
        endcase
    end

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    assign imm_ext = {{20{instr[31]}}, instr[31:20]};

    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        reg_write = 1'b0;
        case (instr[6:0])
            OP_R: begin
                alu_op    = funct3_op(instr[14:12], instr[30]);
                reg_write = 1'b1;
            end
            OP_I: begin
                alu_op    = funct3_op(instr[14:12], 1'b0);
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 is not stored; it is hardwired to zero at the read ports
    assign rd1  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rd2  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign op_b = use_imm ? imm_ext : rd2;

    alu u_alu (
        .a_i      (rd1),
        .b_i      (op_b),
        .op_i     (alu_op),
        .result_o (result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'd3000 + 32'(i);
            end
        end else if (reg_write && rd != 5'd0) begin
            regs_q[rd] <= result;
        end
    end

    assign pc_out_check             = pc_q;
    assign instruction_check        = instr;
    assign alu_op_check             = alu_op;
    assign register_data_out1_check = rd1;
    assign register_data_out2_check = rd2;
    assign register_data_in_check   = result;
    assign alu_result_check         = result;
    assign reg_write_check          = reg_write;
    assign imm_ext_check            = imm_ext;
    assign use_imm_check            = use_imm;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed sequence plus random resets vs a behavioural model.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_o, instr_o, rd1_o, rd2_o, din_o, res_o, imm_o;
    logic [2:0]  op_o;
    logic        rw_o, ui_o;

    int passed = 0;
    int total  = 0;

    cpu_core dut (
        .clk                      (clk),
        .reset                    (reset),
        .pc_out_check             (pc_o),
        .instruction_check        (instr_o),
        .alu_op_check             (op_o),
        .register_data_out1_check (rd1_o),
        .register_data_out2_check (rd2_o),
        .register_data_in_check   (din_o),
        .alu_result_check         (res_o),
        .reg_write_check          (rw_o),
        .imm_ext_check            (imm_o),
        .use_imm_check            (ui_o)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] pc_m;
    logic [31:0] regs_m [32];
    logic [31:0] rom_m  [64];
    int          f3map  [8] = '{0, 5, 7, 7, 4, 6, 3, 2};

    typedef struct {
        logic [31:0] instr;
        int          op;
        logic [31:0] a, b, imm, res;
        logic        rw, ui;
        int          rd;
    } exp_t;

    function automatic logic [31:0] mdl_alu(int op, logic [31:0] a,
                                            logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << b[4:0];
            6: return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        logic [31:0] w;
        logic        is_r, is_i;
        w       = rom_m[pc_m[7:2]];
        e.instr = w;
        is_r    = (w[6:0] == 7'b0110011);
        is_i    = (w[6:0] == 7'b0010011);
        e.rw    = is_r || is_i;
        e.ui    = is_i;
        e.op    = e.rw ? f3map[w[14:12]] : 0;
        if (is_r && w[14:12] == 3'b000 && w[30]) e.op = 1;
        e.imm   = 32'($signed(w[31:20]));
        e.a     = regs_m[w[19:15]];
        e.b     = regs_m[w[24:20]];
        e.res   = mdl_alu(e.op, e.a, e.ui ? e.imm : e.b);
        e.rd    = int'(w[11:7]);
        return e;
    endfunction

    task automatic model_reset();
        pc_m      = 32'd0;
        regs_m[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs_m[i] = 32'd3000 + 32'(i);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            exp_t e;
            e = model_eval();
            if (e.rw && e.rd != 0) regs_m[e.rd] = e.res;
            pc_m = pc_m + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            exp_t e;
            e = model_eval();
            chk("pc",     pc_o,    pc_m);
            chk("instr",  instr_o, e.instr);
            chk("alu_op", 32'(op_o), 32'(e.op));
            chk("rs1",    rd1_o,   e.a);
            chk("rs2",    rd2_o,   e.b);
            chk("din",    din_o,   e.res);
            chk("result", res_o,   e.res);
            chk("rw",     32'(rw_o), 32'(e.rw));
            chk("imm",    imm_o,   e.imm);
            chk("ui",     32'(ui_o), 32'(e.ui));
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) rom_m[i] = 32'h0000_0013;
        rom_m[0] = 32'h0053_03b3;
        rom_m[1] = 32'h4084_8533;
        rom_m[2] = 32'h0016_0693;

        // Pin the model ALU with hand-computed values
        chk("m_add", mdl_alu(0, 4, 2), 32'd6);
        chk("m_sub", mdl_alu(1, 4, 2), 32'd2);
        chk("m_and", mdl_alu(2, 4, 2), 32'd0);
        chk("m_or",  mdl_alu(3, 4, 2), 32'd6);
        chk("m_xor", mdl_alu(4, 4, 2), 32'd6);
        chk("m_sll", mdl_alu(5, 4, 2), 32'd16);
        chk("m_srl", mdl_alu(6, 4, 2), 32'd1);
        chk("m_slt", mdl_alu(7, 4, 2), 32'd0);
        chk("m_sltn", mdl_alu(7, 32'hffff_ffff, 0), 32'd1);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r_pc",    pc_o,    32'd0);
        chk("r_instr", instr_o, 32'h0053_03b3);
        chk("r_op",    32'(op_o), 32'd0);
        chk("r_rs1",   rd1_o,   32'd3006);
        chk("r_rs2",   rd2_o,   32'd3005);
        chk("r_res",   res_o,   32'd6011);
        chk("r_ui",    32'(ui_o), 32'd0);

        @(posedge clk); #1;
        chk("s_pc",    pc_o,    32'd4);
        chk("s_instr", instr_o, 32'h4084_8533);
        chk("s_op",    32'(op_o), 32'd1);
        chk("s_rs1",   rd1_o,   32'd3009);
        chk("s_rs2",   rd2_o,   32'd3008);
        chk("s_res",   res_o,   32'd1);
        chk("s_rw",    32'(rw_o), 32'd1);

        @(posedge clk); #1;
        chk("a_pc",  pc_o,  32'd8);
        chk("a_op",  32'(op_o), 32'd0);
        chk("a_imm", imm_o, 32'd1);
        chk("a_ui",  32'(ui_o), 32'd1);
        chk("a_res", res_o, 32'd3013);

        @(posedge clk); #1;
        chk("x13", dut.regs_q[13], 32'd3013);
        chk("x7",  dut.regs_q[7],  32'd6011);
        chk("x10", dut.regs_q[10], 32'd1);
        chk("m_x13", regs_m[13], 32'd3013);

        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("ar_pc",  pc_o, 32'd0);
        chk("ar_x7",  dut.regs_q[7],  32'd3007);
        chk("ar_x10", dut.regs_q[10], 32'd3010);
        reset = 1'b0;

        repeat (63) @(posedge clk);
        #1;
        chk("w_pc",    pc_o,    32'd252);
        chk("w_instr", instr_o, 32'h0000_0013);
        chk("w_rw",    32'(rw_o), 32'd1);
        chk("w_x0",    rd1_o,   32'd0);
        chk("w_res",   res_o,   32'd0);
        @(posedge clk); #1;
        chk("w2_pc",    pc_o,    32'd256);
        chk("w2_instr", instr_o, 32'h0053_03b3);
        chk("w2_res",   res_o,   32'd6011);

        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                #1 reset = 1'b1;
                #1;
                chk("rr_pc", pc_o, 32'd0);
                #($urandom_range(1, 2)) reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
